line_fifo_ctrl: RTL

LINE_FIFO_CTRL -- requirements
Module: line_fifo_ctrl

---
 rtl/line_fifo_ctrl_pkg.sv | 28 ++
 rtl/line_ptr_mod.sv | 18 +
 rtl/line_fifo_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/line_fifo_ctrl_pkg.sv
// Shared scaler definitions for the line FIFO controller: FSM encoding,
// default widths and the jump-step decode used by the read pointer.
package line_fifo_ctrl_pkg;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_ADDRESS_WIDTH = 11;
    localparam int DEF_LINE_NUM      = 4;
    localparam int DEF_BUFFER_SIZE   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Lines released by the calculation unit; jmp2 wins when both are set.
    function automatic logic [1:0] jump_step(input logic jmp1, input logic jmp2);
        if (jmp2) begin
            return 2'd2;
        end
        if (jmp1) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

endpackage

// File: rtl/line_ptr_mod.sv
// Line-buffer pointer advance: ptr + inc (0, 1 or 2) modulo LINE_NUM.
// LINE_NUM is a power of two, so the modulo is a plain truncation.
module line_ptr_mod #(
    parameter int LINE_NUM = 4
) (
    input  logic [$clog2(LINE_NUM)-1:0] ptr_i,
    input  logic [1:0]                  inc_i,
    output logic [$clog2(LINE_NUM)-1:0] ptr_o
);

    localparam int LW = $clog2(LINE_NUM);

    logic [LW:0] sum;

    assign sum   = {1'b0, ptr_i} + (LW+1)'(inc_i);
    assign ptr_o = sum[LW-1:0];

endmodule

// File: rtl/line_fifo_ctrl.sv
// Line FIFO controller: tracks which external line buffer is being written,
// which lines the calculation unit reads, and how many complete lines are held.
// Handshake: a pixel is accepted on a rising edge when inEn && inReady; inEn
// while inReady is low drops the pixel and sets the sticky ovfErr.
// ramAddrIn is the next column to write, so wrEn/wrData (one cycle after the
// accept) appear together with the already advanced column and line pointers.
module line_fifo_ctrl
    import line_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int LINE_NUM      = DEF_LINE_NUM,
    parameter int BUFFER_SIZE   = DEF_BUFFER_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inVS,
    input  logic                        inEn,
    input  logic [DATA_WIDTH-1:0]       inData,
    input  logic [ADDRESS_WIDTH-1:0]    inXNum,
    input  logic                        jmp1,
    input  logic                        jmp2,
    input  logic                        calVS,
    output logic                        inReady,
    output logic                        wrEn,
    output logic [$clog2(LINE_NUM)-1:0] wrLine,
    output logic [ADDRESS_WIDTH-1:0]    ramAddrIn,
    output logic [DATA_WIDTH-1:0]       wrData,
    output logic [$clog2(LINE_NUM)-1:0] rdLine0,
    output logic [$clog2(LINE_NUM)-1:0] rdLine1,
    output logic [BUFFER_SIZE-1:0]      fifoNum,
    output logic                        ovfErr,
    output logic                        undErr,
    output state_t                      state_o
);

    localparam int LW = $clog2(LINE_NUM);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] xnum_q, xnum_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]            wr_line_q, wr_line_d, wr_line_adv;
    logic [LW-1:0]            rd_line_q, rd_line_d, rd_line_adv;
    logic [BUFFER_SIZE-1:0]   fifo_q, fifo_d;
    logic                     wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic                     ovf_q, ovf_d;
    logic                     und_q, und_d;
    logic                     flush_vs_q, flush_vs_d;

    logic       active;
    logic       flush_req;
    logic       accept;
    logic       complete;
    logic       under;
    logic [1:0] step;
    logic [1:0] eff;

    assign active    = (state_q == ST_FILL) || (state_q == ST_FULL);
    assign inReady   = (state_q == ST_FILL);
    assign flush_req = active && (inVS || calVS);
    assign accept    = inEn && inReady && !flush_req;
    assign complete  = accept && (addr_q == xnum_q - ADDRESS_WIDTH'(1));
    assign step      = (active && !flush_req) ? jump_step(jmp1, jmp2) : 2'd0;
    // A jump larger than the held count only releases what is actually held.
    assign under     = (BUFFER_SIZE'(step) > fifo_q);
    assign eff       = under ? fifo_q[1:0] : step;

    line_ptr_mod #(.LINE_NUM(LINE_NUM)) u_wr_ptr (
        .ptr_i (wr_line_q),
        .inc_i ({1'b0, complete}),
        .ptr_o (wr_line_adv)
    );

    line_ptr_mod #(.LINE_NUM(LINE_NUM)) u_rd_ptr (
        .ptr_i (rd_line_q),
        .inc_i (eff),
        .ptr_o (rd_line_adv)
    );

    line_ptr_mod #(.LINE_NUM(LINE_NUM)) u_rd_next (
        .ptr_i (rd_line_q),
        .inc_i (2'd1),
        .ptr_o (rdLine1)
    );

    // Next-state, pointer and flag logic for the IDLE/FILL/FULL/FLUSH machine.
    always_comb begin
        state_d    = state_q;
        xnum_d     = xnum_q;
        addr_d     = addr_q;
        wr_line_d  = wr_line_q;
        rd_line_d  = rd_line_q;
        fifo_d     = fifo_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        ovf_d      = ovf_q || (inEn && !inReady);
        und_d      = und_q;
        flush_vs_d = flush_vs_q;
        case (state_q)
            ST_IDLE: begin
                if (inVS) begin
                    xnum_d  = inXNum;
                    state_d = ST_FILL;
                end
            end
            ST_FILL, ST_FULL: begin
                if (flush_req) begin
                    // Pointers clear on entry so the FLUSH cycle already shows zeros.
                    state_d    = ST_FLUSH;
                    flush_vs_d = inVS;
                    if (inVS) begin
                        xnum_d = inXNum;
                    end
                    addr_d    = '0;
                    wr_line_d = '0;
                    rd_line_d = '0;
                    fifo_d    = '0;
                end else begin
                    if (accept) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = inData;
                        addr_d    = complete ? '0 : addr_q + ADDRESS_WIDTH'(1);
                    end
                    if (under) begin
                        und_d = 1'b1;
                    end
                    // Completion and release land in one update of the count.
                    fifo_d    = fifo_q - BUFFER_SIZE'(eff) + BUFFER_SIZE'(complete);
                    wr_line_d = wr_line_adv;
                    rd_line_d = rd_line_adv;
                    if (complete && (fifo_d == BUFFER_SIZE'(LINE_NUM - 1))) begin
                        state_d = ST_FULL;
                    end else if ((state_q == ST_FULL) && (eff != 2'd0)) begin
                        state_d = ST_FILL;
                    end
                end
            end
            default: begin
                state_d    = flush_vs_q ? ST_FILL : ST_IDLE;
                flush_vs_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            xnum_q     <= '0;
            addr_q     <= '0;
            wr_line_q  <= '0;
            rd_line_q  <= '0;
            fifo_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            ovf_q      <= 1'b0;
            und_q      <= 1'b0;
            flush_vs_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            xnum_q     <= xnum_d;
            addr_q     <= addr_d;
            wr_line_q  <= wr_line_d;
            rd_line_q  <= rd_line_d;
            fifo_q     <= fifo_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            ovf_q      <= ovf_d;
            und_q      <= und_d;
            flush_vs_q <= flush_vs_d;
        end
    end

    assign wrEn      = wr_en_q;
    assign wrData    = wr_data_q;
    assign ramAddrIn = addr_q;
    assign wrLine    = wr_line_q;
    assign rdLine0   = rd_line_q;
    assign fifoNum   = fifo_q;
    assign ovfErr    = ovf_q;
    assign undErr    = und_q;
    assign state_o   = state_q;

endmodule
